// File: rtl/y86_seq_ctrl_pkg.sv
// Shared definitions for the Y86-64 SEQ sequencer:
// instruction codes, status codes, FSM encoding.
package y86_seq_ctrl_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [2:0] {
        S_AOK = 3'd1,
        S_HLT = 3'd2,
        S_ADR = 3'd3,
        S_INS = 3'd4
    } stat_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRBACK,
        ST_PCUPD,
        ST_HALT
    } state_e;

    function automatic logic is_mem_op(input logic [3:0] ic);
        return ic inside {I_RMMOVQ, I_MRMOVQ, I_CALL,
                          I_RET, I_PUSHQ, I_POPQ};
    endfunction

endpackage

// File: rtl/y86_seq_ctrl_if.sv
// Datapath-facing bundle of the sequencer: fetch/execute
// results, data-memory handshake, PC and stage enables.
interface y86_seq_ctrl_if #(
    parameter int PC_W = 64
) ();
    logic [3:0]      icode;
    logic            imem_error;
    logic            cnd;
    logic [PC_W-1:0] valC;
    logic [PC_W-1:0] valP;
    logic [PC_W-1:0] valM;
    logic            mem_ready;
    logic            dmem_error;
    logic [PC_W-1:0] pc;
    logic            f_en;
    logic            d_en;
    logic            e_en;
    logic            m_en;
    logic            w_en;

    modport master (
        input  icode, imem_error, cnd, valC, valP, valM,
        input  mem_ready, dmem_error,
        output pc, f_en, d_en, e_en, m_en, w_en
    );

    modport slave (
        output icode, imem_error, cnd, valC, valP, valM,
        output mem_ready, dmem_error,
        input  pc, f_en, d_en, e_en, m_en, w_en
    );
endinterface

// File: rtl/y86_seq_ctrl_next_pc.sv
// New-PC select for the PC-update stage of the SEQ machine.
module y86_seq_ctrl_next_pc
    import y86_seq_ctrl_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic [3:0]      icode_i,
    input  logic            cnd_i,
    input  logic [PC_W-1:0] valc_i,
    input  logic [PC_W-1:0] valp_i,
    input  logic [PC_W-1:0] valm_i,
    output logic [PC_W-1:0] pc_o
);
    always_comb begin
        pc_o = valp_i;
        unique case (1'b1)
            (icode_i == I_CALL):         pc_o = valc_i;
            (icode_i == I_RET):          pc_o = valm_i;
            (icode_i == I_JXX && cnd_i): pc_o = valc_i;
            default:                     pc_o = valp_i;
        endcase
    end
endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle SEQ sequencer: six-stage walk per instruction,
// owns PC, status, retired count and memory timeout.
module y86_seq_ctrl
    import y86_seq_ctrl_pkg::*;
#(
    parameter int              PC_W        = 64,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              MEM_TIMEOUT = 16,
    parameter int              CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             stop_i,
    y86_seq_ctrl_if.master   bus,
    output logic [2:0]       stat_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] retired_o
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_e          state_q, state_d;
    stat_e           stat_q, stat_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] valm_q, valm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [3:0]      icode_q, icode_d;
    logic            cnd_q, cnd_d;
    logic [4:0]      en_q, en_d;
    logic [PC_W-1:0] npc;

    y86_seq_ctrl_next_pc #(.PC_W(PC_W)) u_npc (
        .icode_i (icode_q),
        .cnd_i   (cnd_q),
        .valc_i  (bus.valC),
        .valp_i  (bus.valP),
        .valm_i  (valm_q),
        .pc_o    (npc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stat_q  <= S_AOK;
            pc_q    <= RESET_PC;
            valm_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            icode_q <= I_HALT;
            cnd_q   <= 1'b0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            pc_q    <= pc_d;
            valm_q  <= valm_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            icode_q <= icode_d;
            cnd_q   <= cnd_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        pc_d    = pc_q;
        valm_d  = valm_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        icode_d = icode_q;
        cnd_d   = cnd_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_FETCH;
            ST_FETCH: begin
                icode_d = bus.icode;
                unique case (1'b1)
                    bus.imem_error: begin
                        stat_d  = S_ADR;
                        state_d = ST_HALT;
                    end
                    (!bus.imem_error && bus.icode > I_POPQ): begin
                        stat_d  = S_INS;
                        state_d = ST_HALT;
                    end
                    (!bus.imem_error && bus.icode == I_HALT): begin
                        stat_d  = S_HLT;
                        state_d = ST_HALT;
                    end
                    default: state_d = ST_DECODE;
                endcase
            end
            ST_DECODE: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                cnd_d   = bus.cnd;
                tmo_d   = '0;
                state_d = ST_MEMORY;
            end
            ST_MEMORY: begin
                if (!is_mem_op(icode_q)) begin
                    state_d = ST_WRBACK;
                end else if (bus.mem_ready) begin
                    if (bus.dmem_error) begin
                        stat_d  = S_ADR;
                        state_d = ST_HALT;
                    end else begin
                        valm_d  = bus.valM;
                        state_d = ST_WRBACK;
                    end
                end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) begin
                    stat_d  = S_ADR;
                    state_d = ST_HALT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_WRBACK: state_d = ST_PCUPD;
            ST_PCUPD: begin
                pc_d    = npc;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = stop_i ? ST_IDLE : ST_FETCH;
            end
            ST_HALT: begin
                if (start_i) begin
                    pc_d    = RESET_PC;
                    stat_d  = S_AOK;
                    cnt_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // enables follow the state being entered, so they line up with it
    always_comb begin
        en_d    = '0;
        en_d[4] = (state_d == ST_FETCH);
        en_d[3] = (state_d == ST_DECODE);
        en_d[2] = (state_d == ST_EXECUTE);
        en_d[1] = (state_d == ST_MEMORY) && is_mem_op(icode_d);
        en_d[0] = (state_d == ST_WRBACK);
    end

    assign {bus.f_en, bus.d_en, bus.e_en, bus.m_en, bus.w_en} = en_q;
    assign bus.pc    = pc_q;
    assign stat_o    = stat_q;
    assign halted_o  = (state_q == ST_HALT);
    assign retired_o = cnt_q;

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Scoreboard bench for y86_seq_ctrl: driver issues instructions
// against a reference model, monitor checks each completion.
module tb_y86_seq_ctrl;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] retired;

    y86_seq_ctrl_if #(.PC_W(64)) bus ();

    y86_seq_ctrl #(
        .PC_W(64), .RESET_PC(64'd0),
        .MEM_TIMEOUT(TMO), .CNT_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_i(start), .stop_i(stop),
        .bus(bus),
        .stat_o(stat), .halted_o(halted),
        .retired_o(retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] fpc;
        logic [63:0] pc;
        logic [2:0]  stat;
        logic        halted;
        logic [31:0] retired;
        int          lat;
        int          mcnt;
    } exp_t;

    exp_t sb[$];

    // architectural reference state
    logic [63:0] m_pc = 64'd0;
    logic [2:0]  m_stat = 3'd1;
    logic        m_halt = 1'b0;
    logic [31:0] m_ret = 32'd0;

    // monitor
    bit          mon_en = 1'b0;
    int          cyc = 0, fcyc = 0, mcnt = 0, viol = 0, idle = 0;
    logic [63:0] fpc = 64'd0;
    logic [2:0]  fstat = 3'd0;
    logic [31:0] p_ret = 32'd0;
    logic        p_halt = 1'b0;
    exp_t        me;
    bit          ev;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            mcnt += int'(bus.m_en);
            if ($countones({bus.f_en, bus.d_en, bus.e_en,
                            bus.m_en, bus.w_en}) > 1)
                viol++;
            ev = (retired != p_ret && !(p_halt && !halted)) ||
                 (halted && !p_halt);
            if (ev) begin
                idle = 0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: pc %0d stat %0d",
                             bus.pc, stat);
                end else begin
                    me = sb.pop_front();
                    chk("fetch_pc", fpc, me.fpc);
                    chk("fetch_stat", 64'(fstat), 64'd1);
                    chk("pc", bus.pc, me.pc);
                    chk("stat", 64'(stat), 64'(me.stat));
                    chk("halted", 64'(halted), 64'(me.halted));
                    chk("retired", 64'(retired), 64'(me.retired));
                    chk("latency", 64'(cyc - fcyc), 64'(me.lat));
                    chk("m_en_cycles", 64'(mcnt), 64'(me.mcnt));
                    chk("enable_onehot", 64'(viol), 64'd0);
                end
            end else if (sb.size() > 0) begin
                idle++;
                if (idle > 100) begin
                    void'(sb.pop_front());
                    checks++;
                    errors++;
                    $display("FAIL completion_timeout: got none expected 1");
                    idle = 0;
                end
            end
            if (bus.f_en) begin
                fcyc  = cyc;
                fpc   = bus.pc;
                fstat = stat;
                mcnt  = 0;
                viol  = 0;
            end
            p_ret  = retired;
            p_halt = halted;
        end
    end

    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (bus.f_en) ok = 1'b1;
            else begin
                start = 1'b1;
                @(negedge clk);
            end
        end
    endtask

    task automatic issue(input logic [3:0] ic, input bit ierr,
                         input bit cn, input logic [63:0] vc,
                         input logic [63:0] vp, input logic [63:0] vm,
                         input int stalls, input bit derr, input bit stp);
        exp_t e;
        bit ok, memop, done;
        int k;
        logic [31:0] r0;
        wait_fetch(ok);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL fetch_wait: got f_en 0 expected 1");
            start = 1'b0;
            return;
        end
        if (m_halt) begin
            m_pc = 64'd0; m_stat = 3'd1; m_ret = 32'd0; m_halt = 1'b0;
        end
        bus.icode = ic; bus.imem_error = ierr; bus.cnd = cn;
        bus.valC = vc; bus.valP = vp; bus.valM = vm;
        stop = stp;
        start = 1'($urandom_range(0, 1));
        e.fpc = m_pc;
        e.mcnt = 0;
        e.lat = 1;
        memop = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        if (ierr) begin
            m_stat = 3'd3; m_halt = 1'b1;
        end else if (ic > 4'hB) begin
            m_stat = 3'd4; m_halt = 1'b1;
        end else if (ic == 4'h0) begin
            m_stat = 3'd2; m_halt = 1'b1;
        end else if (memop && stalls >= TMO) begin
            m_stat = 3'd3; m_halt = 1'b1;
            e.lat = 3 + TMO; e.mcnt = TMO;
        end else if (memop && derr) begin
            m_stat = 3'd3; m_halt = 1'b1;
            e.lat = 4 + stalls; e.mcnt = stalls + 1;
        end else begin
            case (ic)
                4'h8:    m_pc = vc;
                4'h9:    m_pc = vm;
                4'h7:    m_pc = cn ? vc : vp;
                default: m_pc = vp;
            endcase
            m_ret++;
            e.lat  = 6 + (memop ? stalls : 0);
            e.mcnt = memop ? stalls + 1 : 0;
        end
        e.pc = m_pc; e.stat = m_stat;
        e.halted = m_halt; e.retired = m_ret;
        sb.push_back(e);
        r0 = retired;
        k = 0;
        done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            if (halted || retired != r0) begin
                done = 1'b1;
                start = 1'b0;
                bus.mem_ready = 1'b0;
            end else begin
                start = 1'($urandom_range(0, 1));
                if (bus.m_en) begin
                    bus.mem_ready  = (k >= stalls);
                    bus.dmem_error = (k >= stalls) ? derr
                                   : 1'($urandom_range(0, 1));
                    k++;
                end else begin
                    bus.mem_ready  = 1'($urandom_range(0, 1));
                    bus.dmem_error = 1'($urandom_range(0, 1));
                    if (k > 0) bus.valM = {$urandom, $urandom};
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL run_wait: got no completion expected one");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    bit ok;

    initial begin
        rst_n = 1'b0;
        bus.icode = 4'h1; bus.imem_error = 1'b0; bus.cnd = 1'b0;
        bus.valC = '0; bus.valP = '0; bus.valM = '0;
        bus.mem_ready = 1'b0; bus.dmem_error = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pc", bus.pc, 64'd0);
        chk("rst_stat", 64'(stat), 64'd1);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_retired", 64'(retired), 64'd0);
        chk("rst_en", 64'({bus.f_en, bus.d_en, bus.e_en,
                           bus.m_en, bus.w_en}), 64'd0);
        mon_en = 1'b1;
        rst_n = 1'b1;

        issue(4'h3, 0, 0, 64'd0, 64'd10, 64'd0, 0, 0, 0);
        issue(4'h7, 0, 1, 64'd39, 64'd50, 64'd0, 0, 0, 0);
        issue(4'h7, 0, 0, 64'd39, 64'd50, 64'd0, 0, 0, 0);
        issue(4'h5, 0, 0, 64'd0, 64'd77, 64'd5, 3, 0, 0);
        issue(4'h9, 0, 0, 64'd0, 64'd90, 64'd6, 99, 0, 0);
        issue(4'h7, 0, 1, 64'd124, 64'd8, 64'd0, 0, 0, 0);
        issue(4'h0, 0, 0, 64'd0, 64'd1, 64'd0, 0, 0, 0);
        issue(4'hC, 0, 0, 64'd0, 64'd1, 64'd0, 0, 0, 0);
        issue(4'h8, 0, 0, 64'd300, 64'd20, 64'd0, 0, 0, 0);
        issue(4'h9, 0, 0, 64'd0, 64'd21, 64'd888, 2, 0, 0);
        issue(4'h5, 0, 0, 64'd0, 64'd31, 64'd0, 15, 0, 0);
        issue(4'h5, 0, 0, 64'd0, 64'd32, 64'd0, 16, 0, 0);
        issue(4'h4, 0, 0, 64'd0, 64'd33, 64'd0, 1, 1, 0);
        issue(4'h3, 1, 0, 64'd0, 64'd34, 64'd0, 0, 0, 0);
        issue(4'h1, 0, 0, 64'd0, 64'd44, 64'd0, 0, 0, 1);
        issue(4'h2, 0, 0, 64'd0, 64'd55, 64'd0, 0, 0, 0);

        for (int i = 0; i < 70; i++) begin
            logic [3:0] ic;
            int st;
            ic = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15))
                                             : 4'($urandom_range(0, 11));
            st = ($urandom_range(0, 14) == 0) ? int'($urandom_range(15, 17))
                                              : int'($urandom_range(0, 3));
            issue(ic, $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, st,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
        end

        issue(4'h7, 0, 1, 64'd500, 64'd9, 64'd0, 0, 0, 0);
        for (int c = 0; c < 50 && sb.size() > 0; c++) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        mon_en = 1'b0;

        // abandon a stalled load with an asynchronous reset
        wait_fetch(ok);
        start = 1'b0;
        bus.icode = 4'h5; bus.imem_error = 1'b0; bus.mem_ready = 1'b0;
        for (int c = 0; c < 10 && !bus.m_en; c++) @(negedge clk);
        chk("pre_rst_m_en", 64'(bus.m_en), 64'd1);
        chk("pre_rst_pc", bus.pc, 64'd500);
        #2 rst_n = 1'b0;
        #1;
        chk("async_m_en", 64'(bus.m_en), 64'd0);
        chk("async_pc", bus.pc, 64'd0);
        chk("async_stat", 64'(stat), 64'd1);
        chk("async_retired", 64'(retired), 64'd0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_hold_f_en", 64'(bus.f_en), 64'd0);
        chk("rst_hold_halted", 64'(halted), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_f_en", 64'(bus.f_en), 64'd1);
        chk("post_rst_pc", bus.pc, 64'd0);
        start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
